// File: rtl/widths_logic_pkg.sv
// Shared types and defaults for the widths_logic compare/reduce pipeline.
// Holds the reduction-source enum, the result flag bundle and the parameter defaults.
package widths_logic_pkg;

   localparam int unsigned DefaultWidth = 4;
   localparam int unsigned DefaultCntW  = 8;

   typedef enum logic [1:0] {
      RED_X   = 2'd0,
      RED_Y   = 2'd1,
      RED_XOR = 2'd2,
      RED_AND = 2'd3
   } mode_e;

   typedef struct packed {
      logic eq;
      logic neq;
      logic gt;
      logic red_and;
      logic red_or;
      logic red_xor;
   } flags_t;

endpackage

// File: rtl/widths_logic_core.sv
// Pure combinational compare and reduce logic for one operand pair.
// Flat ports so it can be wrapped single-cycle or dropped into a pipeline stage.
module widths_logic_core
   import widths_logic_pkg::*;
#(
   parameter int unsigned WIDTH  = DefaultWidth,
   parameter bit          SIGNED = 1'b0
) (
   input  logic [WIDTH-1:0] x_i,
   input  logic [WIDTH-1:0] y_i,
   input  mode_e            mode_i,
   output logic             eq_o,
   output logic             neq_o,
   output logic             gt_o,
   output logic             red_and_o,
   output logic             red_or_o,
   output logic             red_xor_o
);

   logic [WIDTH-1:0] sel;

   assign eq_o  = (x_i == y_i);
   assign neq_o = ~eq_o;

   // With WIDTH=1 a signed compare naturally reads a set bit as -1.
   if (SIGNED) begin : g_signed
      assign gt_o = $signed(x_i) > $signed(y_i);
   end else begin : g_unsigned
      assign gt_o = x_i > y_i;
   end

   always_comb begin
      sel = x_i;
      case (mode_i)
         RED_X:   sel = x_i;
         RED_Y:   sel = y_i;
         RED_XOR: sel = x_i ^ y_i;
         RED_AND: sel = x_i & y_i;
         default: sel = x_i;
      endcase
   end

   assign red_and_o = &sel;
   assign red_or_o  = |sel;
   assign red_xor_o = ^sel;

endmodule

// File: rtl/widths_logic_pipe.sv
// Two-stage valid/ready pipeline around widths_logic_core with saturating
// statistics counters for delivered eq and gt results.
module widths_logic_pipe
   import widths_logic_pkg::*;
#(
   parameter int unsigned WIDTH  = DefaultWidth,
   parameter bit          SIGNED = 1'b0,
   parameter int unsigned CNT_W  = DefaultCntW
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic [1:0]       mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             eq,
   output logic             neq,
   output logic             gt,
   output logic             red_and,
   output logic             red_or,
   output logic             red_xor,
   input  logic             clr_cnt,
   output logic [CNT_W-1:0] eq_cnt,
   output logic [CNT_W-1:0] gt_cnt
);

   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] x_q, x_d;
   logic [WIDTH-1:0] y_q, y_d;
   mode_e            mode_q, mode_d;
   logic             s2_valid_q, s2_valid_d;
   flags_t           flags_q, flags_d;
   flags_t           core_flags;
   logic [CNT_W-1:0] eq_cnt_q, eq_cnt_d;
   logic [CNT_W-1:0] gt_cnt_q, gt_cnt_d;

   logic s2_adv;
   logic in_fire;
   logic out_fire;

   assign s2_adv   = ~s2_valid_q | out_ready;
   // Gated by rst_n so in_ready stays low for the whole reset pulse.
   assign in_ready = rst_n & (~s1_valid_q | s2_adv);
   assign in_fire  = in_valid & in_ready;
   assign out_fire = s2_valid_q & out_ready;

   widths_logic_core #(
      .WIDTH  (WIDTH),
      .SIGNED (SIGNED)
   ) u_core (
      .x_i       (x_q),
      .y_i       (y_q),
      .mode_i    (mode_q),
      .eq_o      (core_flags.eq),
      .neq_o     (core_flags.neq),
      .gt_o      (core_flags.gt),
      .red_and_o (core_flags.red_and),
      .red_or_o  (core_flags.red_or),
      .red_xor_o (core_flags.red_xor)
   );

   always_comb begin
      s1_valid_d = s1_valid_q;
      x_d        = x_q;
      y_d        = y_q;
      mode_d     = mode_q;
      s2_valid_d = s2_valid_q;
      flags_d    = flags_q;

      if (in_fire) begin
         s1_valid_d = 1'b1;
         x_d        = x;
         y_d        = y;
         mode_d     = mode_e'(mode);
      end else if (s2_adv) begin
         s1_valid_d = 1'b0;
      end

      if (s2_adv) begin
         s2_valid_d = s1_valid_q;
         // Flags only reload with real data; holding them avoids needless toggling.
         if (s1_valid_q) begin
            flags_d = core_flags;
         end
      end
   end

   always_comb begin
      eq_cnt_d = eq_cnt_q;
      gt_cnt_d = gt_cnt_q;
      if (clr_cnt) begin
         eq_cnt_d = '0;
         gt_cnt_d = '0;
      end else if (out_fire) begin
         if (flags_q.eq && (eq_cnt_q != {CNT_W{1'b1}})) begin
            eq_cnt_d = eq_cnt_q + CNT_W'(1);
         end
         if (flags_q.gt && (gt_cnt_q != {CNT_W{1'b1}})) begin
            gt_cnt_d = gt_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         x_q        <= '0;
         y_q        <= '0;
         mode_q     <= RED_X;
         s2_valid_q <= 1'b0;
         flags_q    <= '0;
         eq_cnt_q   <= '0;
         gt_cnt_q   <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         x_q        <= x_d;
         y_q        <= y_d;
         mode_q     <= mode_d;
         s2_valid_q <= s2_valid_d;
         flags_q    <= flags_d;
         eq_cnt_q   <= eq_cnt_d;
         gt_cnt_q   <= gt_cnt_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign eq        = flags_q.eq;
   assign neq       = flags_q.neq;
   assign gt        = flags_q.gt;
   assign red_and   = flags_q.red_and;
   assign red_or    = flags_q.red_or;
   assign red_xor   = flags_q.red_xor;
   assign eq_cnt    = eq_cnt_q;
   assign gt_cnt    = gt_cnt_q;

endmodule

// File: tb/tb_widths_logic_pipe.sv
// Directed bench for widths_logic_pipe: unsigned, signed, WIDTH=1 and CNT_W=2
// instances share one stimulus stream; expected flags are hand-computed.
module tb_widths_logic_pipe;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b1;
   logic       clr_cnt = 1'b0;
   logic [3:0] x = '0;
   logic [3:0] y = '0;
   logic [1:0] mode = '0;

   logic       a_in_ready, a_out_valid, a_eq, a_neq, a_gt, a_rand, a_ror, a_rxor;
   logic [7:0] a_eq_cnt, a_gt_cnt;
   logic       b_in_ready, b_out_valid, b_eq, b_neq, b_gt, b_rand, b_ror, b_rxor;
   logic [1:0] b_eq_cnt, b_gt_cnt;
   logic       c_in_ready, c_out_valid, c_eq, c_neq, c_gt, c_rand, c_ror, c_rxor;
   logic [7:0] c_eq_cnt, c_gt_cnt;

   logic [5:0] fa, fb, fc;
   assign fa = {a_eq, a_neq, a_gt, a_rand, a_ror, a_rxor};
   assign fb = {b_eq, b_neq, b_gt, b_rand, b_ror, b_rxor};
   assign fc = {c_eq, c_neq, c_gt, c_rand, c_ror, c_rxor};

   int n_chk = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   widths_logic_pipe #(.WIDTH(4), .SIGNED(1'b0), .CNT_W(8)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
      .x(x), .y(y), .mode(mode), .out_valid(a_out_valid), .out_ready(out_ready),
      .eq(a_eq), .neq(a_neq), .gt(a_gt), .red_and(a_rand), .red_or(a_ror),
      .red_xor(a_rxor), .clr_cnt(clr_cnt), .eq_cnt(a_eq_cnt), .gt_cnt(a_gt_cnt)
   );

   widths_logic_pipe #(.WIDTH(4), .SIGNED(1'b1), .CNT_W(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
      .x(x), .y(y), .mode(mode), .out_valid(b_out_valid), .out_ready(out_ready),
      .eq(b_eq), .neq(b_neq), .gt(b_gt), .red_and(b_rand), .red_or(b_ror),
      .red_xor(b_rxor), .clr_cnt(clr_cnt), .eq_cnt(b_eq_cnt), .gt_cnt(b_gt_cnt)
   );

   widths_logic_pipe #(.WIDTH(1), .SIGNED(1'b1), .CNT_W(8)) dut_c (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_in_ready),
      .x(x[0]), .y(y[0]), .mode(mode), .out_valid(c_out_valid), .out_ready(out_ready),
      .eq(c_eq), .neq(c_neq), .gt(c_gt), .red_and(c_rand), .red_or(c_ror),
      .red_xor(c_rxor), .clr_cnt(clr_cnt), .eq_cnt(c_eq_cnt), .gt_cnt(c_gt_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   // One pair with out_ready high; returns on the negedge where its result is visible.
   task automatic send1(input logic [3:0] xv, input logic [3:0] yv, input logic [1:0] mv);
      @(negedge clk);
      in_valid = 1'b1;
      x = xv;
      y = yv;
      mode = mv;
      @(negedge clk);
      in_valid = 1'b0;
      chk("lat1_novalid", a_out_valid, 1'b0);
      @(negedge clk);
      chk("lat2_valid", a_out_valid, 1'b1);
   endtask

   initial begin
      // Reset state
      #2;
      chk("rst_out_valid", a_out_valid, 1'b0);
      chk("rst_in_ready", a_in_ready, 1'b0);
      chk("rst_flags", fa, 6'b0);
      chk("rst_eq_cnt", a_eq_cnt, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_rst_in_ready", a_in_ready, 1'b1);

      // Single pairs: {eq,neq,gt,red_and,red_or,red_xor}
      send1(4'd9, 4'd3, 2'd0);
      chk("v1_a", fa, 6'b011010);
      chk("v1_b", fb, 6'b010010);
      send1(4'hF, 4'h1, 2'd3);
      chk("v2_a", fa, 6'b011011);
      chk("v2_b", fb, 6'b010011);
      send1(4'd6, 4'd6, 2'd2);
      chk("v3_a", fa, 6'b100000);
      chk("v3_b", fb, 6'b100000);
      send1(4'd5, 4'hF, 2'd1);
      chk("v4_a", fa, 6'b010110);
      chk("v4_b", fb, 6'b011110);
      send1(4'd1, 4'd0, 2'd0);
      chk("v5_a", fa, 6'b011011);
      chk("v5_b", fb, 6'b011011);
      chk("v5_w1", fc, 6'b010111);
      send1(4'd0, 4'd1, 2'd0);
      chk("v6_a", fa, 6'b010000);
      chk("v6_b", fb, 6'b010000);
      chk("v6_w1", fc, 6'b011000);
      send1(4'd1, 4'd1, 2'd3);
      chk("v7_a", fa, 6'b100011);
      chk("v7_w1", fc, 6'b100111);
      @(negedge clk);
      chk("cnt_a_eq", a_eq_cnt, 8'd2);
      chk("cnt_a_gt", a_gt_cnt, 8'd3);
      chk("cnt_b_eq", b_eq_cnt, 2'd2);
      chk("cnt_b_gt", b_gt_cnt, 2'd2);
      chk("cnt_w1_eq", c_eq_cnt, 8'd5);
      chk("cnt_w1_gt", c_gt_cnt, 8'd1);
      chk("empty_after", a_out_valid, 1'b0);

      // Backpressure stream A, B, C
      in_valid = 1'b1; x = 4'd9; y = 4'd3; mode = 2'd0;
      @(negedge clk);
      x = 4'd5; y = 4'd5; mode = 2'd0;
      @(negedge clk);
      out_ready = 1'b0;
      x = 4'd2; y = 4'd7; mode = 2'd3;
      #1;
      chk("bp_valid_a", a_out_valid, 1'b1);
      chk("bp_in_ready_low", a_in_ready, 1'b0);
      chk("bp_flags_a0", fa, 6'b011010);
      repeat (2) begin
         @(negedge clk);
         chk("bp_hold_valid", a_out_valid, 1'b1);
         chk("bp_hold_flags", fa, 6'b011010);
         chk("bp_hold_in_ready", a_in_ready, 1'b0);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_in_ready", a_in_ready, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      chk("bp_res_b_valid", a_out_valid, 1'b1);
      chk("bp_res_b", fa, 6'b100010);
      @(negedge clk);
      chk("bp_res_c_valid", a_out_valid, 1'b1);
      chk("bp_res_c", fa, 6'b010011);
      @(negedge clk);
      chk("bp_drained", a_out_valid, 1'b0);

      // Saturation on CNT_W=2 and clear beating a simultaneous increment
      clr_cnt = 1'b1;
      @(negedge clk);
      clr_cnt = 1'b0;
      chk("clr_b_eq", b_eq_cnt, 2'd0);
      chk("clr_a_gt", a_gt_cnt, 8'd0);
      for (int cyc = 0; cyc < 9; cyc++) begin
         if (cyc > 0) @(negedge clk);
         if (cyc >= 3 && cyc <= 7) begin
            chk("sat_b_eq", b_eq_cnt, (cyc - 2 > 3) ? 2'd3 : 2'(cyc - 2));
         end
         if (cyc == 7) chk("sat_a_eq", a_eq_cnt, 8'd5);
         if (cyc == 8) begin
            chk("clr_wins_b", b_eq_cnt, 2'd0);
            chk("clr_wins_a", a_eq_cnt, 8'd0);
         end
         in_valid = (cyc < 6);
         x = 4'd3;
         y = 4'd3;
         mode = 2'd0;
         clr_cnt = (cyc == 7);
      end
      in_valid = 1'b0;
      clr_cnt = 1'b0;

      // Reset with both stages full
      @(negedge clk);
      out_ready = 1'b0;
      in_valid = 1'b1; x = 4'd9; y = 4'd3; mode = 2'd0;
      @(negedge clk);
      x = 4'd4; y = 4'd1;
      @(negedge clk);
      in_valid = 1'b0;
      chk("full_valid", a_out_valid, 1'b1);
      chk("full_in_ready", a_in_ready, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", a_out_valid, 1'b0);
      chk("midrst_in_ready", a_in_ready, 1'b0);
      chk("midrst_flags", fa, 6'b0);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      #1;
      chk("rel_in_ready", a_in_ready, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("no_stale", a_out_valid, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/widths_logic_pipe.md
WIDTHS_LOGIC_PIPE -- requirements
Module: widths_logic_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand width in bits (legal range 1..64).
REQ-002 The block SHALL have parameter SIGNED, default 0; when 1, gt SHALL use two's-complement comparison.
REQ-003 The block SHALL have parameter CNT_W, default 8, giving the width of the statistics counters.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in_valid  input  1  operand pair present.
REQ-008 in_ready  output  1  block accepts an operand pair this cycle.
REQ-009 x, y  input  WIDTH each  operands.
REQ-010 mode  input  2  reduction source: 0 = x, 1 = y, 2 = x^y, 3 = x&y; mode is sampled together with the operands.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 eq, neq, gt, red_and, red_or, red_xor  output  1 each  result flags.
REQ-014 clr_cnt  input  1  synchronous counter clear.
REQ-015 eq_cnt, gt_cnt  output  CNT_W each  saturating counts of delivered results with eq=1 and gt=1 respectively.

Function
REQ-016 An input handshake SHALL occur on a cycle with in_valid and in_ready both high; an output handshake SHALL occur on a cycle with out_valid and out_ready both high.
REQ-017 The datapath SHALL be a two-stage pipeline: S1 registers x, y and mode; S2 registers the computed flags. Input-to-output latency SHALL be exactly 2 cycles when out_ready is held high.
REQ-018 S2 SHALL advance when S2 is empty or out_ready is high.
REQ-019 S1 SHALL advance into S2 whenever S2 advances.
REQ-020 in_ready SHALL equal (!s1_valid || S2 advances), so back-to-back transfers sustain 1 result per cycle.
REQ-021 While out_valid is high and out_ready is low, all result outputs SHALL hold stable, and at most 2 operand pairs SHALL be buffered.
REQ-022 eq SHALL be (x==y), neq SHALL be !eq, and gt SHALL be x>y, unsigned or signed per the SIGNED parameter.
REQ-023 red_and, red_or and red_xor SHALL be the AND, OR and XOR reductions of the mode-selected WIDTH-bit vector.
REQ-024 When WIDTH=1, the signed comparison SHALL treat 1 as -1.
REQ-025 On each output handshake, eq_cnt SHALL increment when eq=1 and gt_cnt SHALL increment when gt=1; both SHALL saturate at 2^CNT_W-1 with no wrap-around.
REQ-026 When clr_cnt is high, both counters SHALL become 0 on the next edge, and clear SHALL win over a simultaneous increment.
REQ-027 Flag outputs SHALL be don't-care while out_valid=0, but SHALL be driven from registers (no combinational path from x or y to any output).

Reset
REQ-028 Asserting rst_n low SHALL immediately clear s1_valid and s2_valid, set out_valid, all flags, eq_cnt and gt_cnt to 0, and drive in_ready to 0 for as long as reset is held.
REQ-029 Reset asserted mid-operation SHALL discard any buffered operand pairs without producing an output handshake.
REQ-030 After reset deassertion, in_ready SHALL be 1 on the first cycle.

Structure
REQ-031 A shared package widths_logic_pkg SHALL hold the 2-bit mode enum (RED_X, RED_Y, RED_XOR, RED_AND) and the default WIDTH and CNT_W constants.
REQ-032 The pure combinational compare/reduce logic SHALL be a sub-module widths_logic_core, parametrised by WIDTH and SIGNED.
REQ-033 The existing single-cycle flattened wrapper style SHALL be reusable around widths_logic_core.

Verification
REQ-034 WIDTH=4, SIGNED=0: x=9, y=3, mode=0, out_ready=1 -> 2 cycles later out_valid=1, eq=0, neq=1, gt=1, red_and=0, red_or=1, red_xor=0.
REQ-035 WIDTH=4, SIGNED=1: x=4'hF, y=4'h1 -> gt=0; the same vectors with SIGNED=0 -> gt=1.
REQ-036 Stream of 3 pairs with out_ready low from the first result onward -> third pair sees in_ready=0; the held result is stable; raising out_ready delivers all 3 results in order with no loss or duplicate.
REQ-037 CNT_W=2, 5 delivered results all with eq=1 -> eq_cnt sequence 1, 2, 3, 3, 3; clr_cnt asserted on the same cycle as a 6th eq handshake -> eq_cnt=0.
REQ-038 rst_n pulsed low with both stages full -> out_valid=0 immediately; after release, in_ready=1 and no stale result appears.
